// File: rtl/div_32_16_seq.sv
// Sequential signed 32/16 divider: radix-2 restoring division on magnitudes, one quotient bit per clock.
// Optional build macro DIV_OVF_SAT_EN saturates QUOT (and zeroes REM) when the quotient overflows.
module div_32_16_seq (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] DIVIDEND,
  input  logic [15:0] DIVISOR,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [15:0] QUOT,
  output logic [15:0] REM,
  output logic        OVF,
  output logic        DIV0
);

  // state | meaning
  // IDLE  | ready for a new operation
  // CALC  | 32 restoring iterations, counter 0..31
  // FIX   | apply signs, detect overflow, register result
  // DONE  | result valid, held until OUT_READY
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;      // dividend magnitude shifts out, quotient shifts in
  logic [15:0] pr_q, pr_d;        // partial remainder
  logic [15:0] dvs_q, dvs_d;
  logic        neg_dvd_q, neg_dvd_d;
  logic        neg_dvs_q, neg_dvs_d;
  logic [15:0] quot_q, quot_d;
  logic [15:0] rem_q, rem_d;
  logic        ovf_q, ovf_d;
  logic        div0_q, div0_d;

  logic [31:0] dvd_abs;
  logic [15:0] dvs_abs;
  logic [16:0] shifted;
  logic [17:0] trial;
  logic        q_neg;
  logic [32:0] q_signed;
  logic [15:0] r_signed;
  logic        q_ovf;

  assign dvd_abs = DIVIDEND[31] ? (32'd0 - DIVIDEND) : DIVIDEND;
  assign dvs_abs = DIVISOR[15]  ? (16'd0 - DIVISOR)  : DIVISOR;

  assign shifted = {pr_q, dvd_q[31]};
  assign trial   = {1'b0, shifted} - {2'b00, dvs_q};

  assign q_neg    = neg_dvd_q ^ neg_dvs_q;
  assign q_signed = q_neg ? (33'd0 - {1'b0, dvd_q}) : {1'b0, dvd_q};
  assign r_signed = neg_dvd_q ? (16'd0 - pr_q) : pr_q;
  // in range iff bits 32..15 are a pure sign extension
  assign q_ovf    = !((&q_signed[32:15]) || (~|q_signed[32:15]));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    pr_d      = pr_q;
    dvs_d     = dvs_q;
    neg_dvd_d = neg_dvd_q;
    neg_dvs_d = neg_dvs_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    ovf_d     = ovf_q;
    div0_d    = div0_q;

    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          dvd_d     = dvd_abs;
          dvs_d     = dvs_abs;
          neg_dvd_d = DIVIDEND[31];
          neg_dvs_d = DIVISOR[15];
          pr_d      = 16'd0;
          cnt_d     = 5'd0;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        // a zero divisor makes every trial succeed; that result is discarded in FIX
        if (!trial[17]) begin
          pr_d  = trial[15:0];
          dvd_d = {dvd_q[30:0], 1'b1};
        end else begin
          pr_d  = shifted[15:0];
          dvd_d = {dvd_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        if (dvs_q == 16'd0) begin
          quot_d = 16'hFFFF;
          rem_d  = 16'h0000;
          ovf_d  = 1'b0;
          div0_d = 1'b1;
        end else begin
          ovf_d  = q_ovf;
          div0_d = 1'b0;
`ifdef DIV_OVF_SAT_EN
          quot_d = q_ovf ? (q_neg ? 16'h8000 : 16'h7FFF) : q_signed[15:0];
          rem_d  = q_ovf ? 16'h0000 : r_signed;
`else
          quot_d = q_signed[15:0];
          rem_d  = r_signed;
`endif
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (OUT_READY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      dvd_q     <= 32'd0;
      pr_q      <= 16'd0;
      dvs_q     <= 16'd0;
      neg_dvd_q <= 1'b0;
      neg_dvs_q <= 1'b0;
      quot_q    <= 16'd0;
      rem_q     <= 16'd0;
      ovf_q     <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      pr_q      <= pr_d;
      dvs_q     <= dvs_d;
      neg_dvd_q <= neg_dvd_d;
      neg_dvs_q <= neg_dvs_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      ovf_q     <= ovf_d;
      div0_q    <= div0_d;
    end
  end

  assign IN_READY  = (state_q == S_IDLE) && !RST;
  assign OUT_VALID = (state_q == S_DONE);
  assign QUOT      = quot_q;
  assign REM       = rem_q;
  assign OVF       = ovf_q;
  assign DIV0      = div0_q;

endmodule
